// File: rtl/gray_pos_tracker.sv
// Gray-coded position tracker: synchronises a 4-bit Gray word, decodes it and
// turns legal +/-1 steps into a wrapping position count, flagging illegal jumps.
module gray_pos_tracker #(
  parameter int POS_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       g_in,
  input  logic             clr_err,
  output logic [3:0]       bin,
  output logic [POS_W-1:0] pos,
  output logic             step_up,
  output logic             step_dn,
  output logic             err,
  output logic [7:0]       err_cnt
);

  typedef enum logic {FILL, TRACK} state_t;

  localparam int FW = $clog2(SYNC_STAGES + 1);
  localparam logic [FW-1:0] FILL_LAST = FW'(SYNC_STAGES - 1);

  state_t                          state;
  logic [FW-1:0]                   fill_cnt;
  logic [SYNC_STAGES-1:0][3:0]     sync_q;
  logic [3:0]                      gs;
  logic [3:0]                      d;
  logic [3:0]                      prev;
  logic [3:0]                      delta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], g_in};
  end

  assign gs = sync_q[SYNC_STAGES-1];

  always_comb begin
    d    = '0;
    d[3] = gs[3];
    d[2] = d[3] ^ gs[2];
    d[1] = d[2] ^ gs[1];
    d[0] = d[1] ^ gs[0];
  end

  // Mod-16 difference: 1 is an up step, 15 a down step, anything else nonzero is a jump.
  assign delta = d - prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FILL;
      fill_cnt <= '0;
      prev     <= '0;
      bin      <= '0;
      pos      <= '0;
      step_up  <= 1'b0;
      step_dn  <= 1'b0;
      err      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      step_up <= 1'b0;
      step_dn <= 1'b0;
      if (clr_err) begin
        err     <= 1'b0;
        err_cnt <= '0;
      end
      case (state)
        FILL: begin
          if (fill_cnt == FILL_LAST) begin
            prev  <= d;
            bin   <= d;
            state <= TRACK;
          end else begin
            fill_cnt <= fill_cnt + 1'b1;
          end
        end
        TRACK: begin
          bin  <= d;
          prev <= d;
          if (en) begin
            if (delta == 4'd1) begin
              step_up <= 1'b1;
              pos     <= pos + 1'b1;
            end else if (delta == 4'hF) begin
              step_dn <= 1'b1;
              pos     <= pos - 1'b1;
            end else if (delta != 4'd0) begin
              // A jump coinciding with clr_err counts as the first error after the clear.
              err <= 1'b1;
              if (clr_err)               err_cnt <= 8'd1;
              else if (err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_gray_pos_tracker.sv
// Bench for gray_pos_tracker: directed segment table, hand-written corner
// sequences and randomized Gray stimulus against a behavioural model.
module tb_gray_pos_tracker;
  localparam int POS_W = 8;
  localparam int S     = 2;
  localparam int PMOD  = 1 << POS_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b1;
  logic             clr_err = 1'b0;
  logic [3:0]       g_in = 4'b0000;
  logic [3:0]       bin;
  logic [POS_W-1:0] pos;
  logic             step_up, step_dn, err;
  logic [7:0]       err_cnt;

  gray_pos_tracker #(.POS_W(POS_W), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .en(en), .g_in(g_in), .clr_err(clr_err),
    .bin(bin), .pos(pos), .step_up(step_up), .step_dn(step_dn),
    .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: a delay line of raw samples plus the step rules.
  logic [3:0] m_hist[$];
  int m_fill, m_prev, m_bin, m_pos, m_err, m_cnt;
  bit m_track, m_up, m_dn;

  function automatic int g2b(int g);
    return (g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3)) & 15;
  endfunction

  function automatic logic [3:0] b2g(int b);
    return 4'((b ^ (b >> 1)) & 15);
  endfunction

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < S; i++) m_hist.push_back(4'b0000);
    m_fill = 0; m_track = 0; m_prev = 0; m_bin = 0; m_pos = 0;
    m_err = 0; m_cnt = 0; m_up = 0; m_dn = 0;
  endtask

  task automatic model_edge();
    int gs, d, delta;
    if (rst) begin
      model_reset();
      return;
    end
    gs = m_hist[S-1];
    m_hist.push_front(g_in);
    void'(m_hist.pop_back());
    d = g2b(gs);
    m_up = 0; m_dn = 0;
    if (clr_err) begin m_err = 0; m_cnt = 0; end
    if (!m_track) begin
      m_fill++;
      if (m_fill == S) begin m_prev = d; m_bin = d; m_track = 1; end
    end else begin
      delta = (d - m_prev + 16) % 16;
      m_bin = d; m_prev = d;
      if (en) begin
        if (delta == 1) begin m_up = 1; m_pos = (m_pos + 1) % PMOD; end
        else if (delta == 15) begin m_dn = 1; m_pos = (m_pos + PMOD - 1) % PMOD; end
        else if (delta != 0) begin m_err = 1; m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255; end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("model", {9'd0, bin, pos, step_up, step_dn, err, err_cnt},
          {9'd0, 4'(m_bin), 8'(m_pos), m_up, m_dn, 1'(m_err), 8'(m_cnt)});
  endtask

  typedef struct {
    logic [3:0] g;
    bit         en;
    int         hold;
    int         bin;
    int         pos;
    int         up_at;
    int         dn_at;
    int         err;
    int         cnt;
  } seg_t;

  seg_t segs[17];

  task automatic apply_seg(input int idx);
    int up_first, dn_first, up_n, dn_n;
    up_first = 0; dn_first = 0; up_n = 0; dn_n = 0;
    g_in = segs[idx].g;
    en   = segs[idx].en;
    for (int i = 1; i <= segs[idx].hold; i++) begin
      tick();
      if (step_up) begin up_n++; if (up_first == 0) up_first = i; end
      if (step_dn) begin dn_n++; if (dn_first == 0) dn_first = i; end
    end
    check($sformatf("seg%0d bin", idx), 32'(bin), 32'(segs[idx].bin));
    check($sformatf("seg%0d pos", idx), 32'(pos), 32'(segs[idx].pos));
    check($sformatf("seg%0d err", idx), 32'(err), 32'(segs[idx].err));
    check($sformatf("seg%0d err_cnt", idx), 32'(err_cnt), 32'(segs[idx].cnt));
    check($sformatf("seg%0d up_at", idx), 32'(up_first), 32'(segs[idx].up_at));
    check($sformatf("seg%0d dn_at", idx), 32'(dn_first), 32'(segs[idx].dn_at));
    check($sformatf("seg%0d pulses", idx), 32'(up_n + dn_n),
          32'((segs[idx].up_at != 0) + (segs[idx].dn_at != 0)));
  endtask

  int cur_b;

  initial begin
    //            g        en hold bin pos up dn err cnt
    segs[0]  = '{4'b0000, 1, 5,  0,  0,   0, 0, 0, 0};
    segs[1]  = '{4'b0001, 1, 4,  1,  1,   3, 0, 0, 0};
    segs[2]  = '{4'b0011, 1, 4,  2,  2,   3, 0, 0, 0};
    segs[3]  = '{4'b0010, 1, 4,  3,  3,   3, 0, 0, 0};
    segs[4]  = '{4'b0011, 1, 4,  2,  2,   0, 3, 0, 0};
    segs[5]  = '{4'b0001, 1, 4,  1,  1,   0, 3, 0, 0};
    segs[6]  = '{4'b0000, 1, 4,  0,  0,   0, 3, 0, 0};
    segs[7]  = '{4'b1000, 1, 4,  15, 255, 0, 3, 0, 0};
    segs[8]  = '{4'b0000, 1, 4,  0,  0,   3, 0, 0, 0};
    segs[9]  = '{4'b0110, 1, 4,  4,  0,   0, 0, 1, 1};
    segs[10] = '{4'b0111, 1, 4,  5,  1,   3, 0, 1, 1};
    segs[11] = '{4'b0101, 0, 4,  6,  1,   0, 0, 1, 1};
    segs[12] = '{4'b0100, 0, 4,  7,  1,   0, 0, 1, 1};
    segs[13] = '{4'b1100, 0, 4,  8,  1,   0, 0, 1, 1};
    segs[14] = '{4'b1101, 0, 4,  9,  1,   0, 0, 1, 1};
    segs[15] = '{4'b1111, 0, 4,  10, 1,   0, 0, 1, 1};
    segs[16] = '{4'b1111, 1, 4,  10, 1,   0, 0, 1, 1};

    model_reset();
    rst = 1'b1;
    #1;
    check("reset outputs", {9'd0, bin, pos, step_up, step_dn, err, err_cnt}, 32'd0);
    tick(); tick();
    rst = 1'b0;

    for (int i = 0; i < 17; i++) apply_seg(i);

    // Clear alone, then drive the counter into saturation.
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("clr alone err", 32'(err), 32'd0);
    check("clr alone cnt", 32'(err_cnt), 32'd0);
    for (int k = 0; k < 260; k++) begin
      g_in = (k % 2 == 0) ? 4'b1100 : 4'b0000;
      tick();
    end
    tick(); tick(); tick();
    check("sat cnt", 32'(err_cnt), 32'd255);
    check("sat err", 32'(err), 32'd1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("clr after sat err", 32'(err), 32'd0);
    check("clr after sat cnt", 32'(err_cnt), 32'd0);

    // Clear coinciding with the edge that registers a new jump.
    g_in = 4'b1100;
    tick(); tick();
    check("pre-jump err", 32'(err), 32'd0);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check("clr+jump err", 32'(err), 32'd1);
    check("clr+jump cnt", 32'(err_cnt), 32'd1);

    // Asynchronous reset mid-run, then refill before any pulse.
    g_in = 4'b1101;
    tick(); tick(); tick();
    check("pre-rst pos", 32'(pos), 32'd2);
    #2;
    rst = 1'b1; g_in = 4'b0001;
    model_reset();
    #1;
    check("async rst outputs", {9'd0, bin, pos, step_up, step_dn, err, err_cnt}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("fill1 up", 32'(step_up), 32'd0);
    tick();
    check("fill2 up", 32'(step_up), 32'd0);
    check("fill2 bin", 32'(bin), 32'd0);
    tick();
    check("post-fill up", 32'(step_up), 32'd1);
    check("post-fill bin", 32'(bin), 32'd1);
    check("post-fill pos", 32'(pos), 32'd1);

    // Randomized walk with occasional jumps, enables, clears and resets.
    cur_b = 1;
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 35)      cur_b = (cur_b + 1) % 16;
      else if (r < 70) cur_b = (cur_b + 15) % 16;
      else if (r < 80) cur_b = $urandom_range(0, 15);
      g_in    = b2g(cur_b);
      en      = ($urandom_range(0, 9) != 0);
      clr_err = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        model_reset();
        #1;
        check("rand async rst", {9'd0, bin, pos, step_up, step_dn, err, err_cnt}, 32'd0);
        tick();
        rst = 1'b0;
      end
      repeat ($urandom_range(1, 4)) tick();
    end
    clr_err = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
